// File: rtl/rr_onehot_arbiter_pkg.sv
// arb_pkg: shared sizes, arbiter state type and the rotating first-set search.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int ID_W = 3;
  localparam int MAX_HOLD = 16;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] idx;
    rr_pick = ptr;
    // walk downward so the set bit closest above ptr is written last and wins
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + ID_W'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// rr_onehot_arbiter_if: request/grant bundle between requesters and the arbiter.
interface rr_onehot_arbiter_if;
  import arb_pkg::*;
  logic en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0] grant_id;
  logic grant_valid;
  logic preempt;
  modport master (output en, req, input grant, grant_id, grant_valid, preempt);
  modport slave (input en, req, output grant, grant_id, grant_valid, preempt);
endinterface

// File: rtl/rr_onehot_arbiter_dec.sv
// onehot_dec_3_8: combinational 3-to-8 one-hot decoder with enable.
module onehot_dec_3_8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);
  assign y = en ? 8'b1 << sel : 8'b0;
endmodule

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: registered round-robin arbiter with one-hot grant; ARB_HOLD_TIMEOUT_EN adds hold timeout/preempt.
module rr_onehot_arbiter
  import arb_pkg::*;
(
  input logic clk,
  input logic rst,
  rr_onehot_arbiter_if.slave bus
);
  arb_state_e state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic preempt_q, preempt_d;
  logic timeout;
`ifdef ARB_HOLD_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  assign timeout = state_q == ARB_GRANT && hold_q == 8'(MAX_HOLD - 1) &&
                   |(bus.req & ~(N_REQ'(1) << id_q));
  assign hold_d = (state_q == ARB_GRANT && state_d == ARB_GRANT) ?
                  (hold_q == 8'(MAX_HOLD - 1) ? hold_q : hold_q + 8'd1) : 8'd0;
  always_ff @(posedge clk) hold_q <= rst ? 8'd0 : hold_d;
`else
  assign timeout = 1'b0;
`endif
  // a requester dropping its bit counts as served even if en falls in the same cycle
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    preempt_d = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (bus.en && |bus.req) begin
        state_d = ARB_GRANT;
        id_d = rr_pick(bus.req, ptr_q);
      end
    end else if (!bus.req[id_q]) begin
      state_d = ARB_IDLE;
      ptr_d = id_q + 1'b1;
    end else if (!bus.en) begin
      state_d = ARB_IDLE;
    end else if (timeout) begin
      state_d = ARB_IDLE;
      ptr_d = id_q + 1'b1;
      preempt_d = 1'b1;
    end
  end
  onehot_dec_3_8 u_dec (.en(state_d == ARB_GRANT), .sel(id_d), .y(grant_d));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q <= '0;
      id_q <= '0;
      grant_q <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      grant_q <= grant_d;
      preempt_q <= preempt_d;
    end
  end
  assign bus.grant = grant_q;
  assign bus.grant_id = id_q;
  assign bus.grant_valid = state_q == ARB_GRANT;
  assign bus.preempt = preempt_q;
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb_rr_onehot_arbiter: directed plus random stimulus against a behavioural round-robin model.
module tb_rr_onehot_arbiter;
  import arb_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  rr_onehot_arbiter_if bus ();
  rr_onehot_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  bit m_busy = 1'b0;
  bit m_pre = 1'b0;
  int m_gid = 0;
  int m_ptr = 0;
  int m_held = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // m_held counts grant cycles including the current one
  task automatic model(input bit r, input bit e, input logic [7:0] q);
    int w = 0;
    bit found = 1'b0;
    m_pre = 1'b0;
    if (r) begin
      m_busy = 1'b0; m_gid = 0; m_ptr = 0; m_held = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < 8; k++)
        if (!found && q[3'((m_ptr + k) % 8)]) begin w = (m_ptr + k) % 8; found = 1'b1; end
      if (e && found) begin m_busy = 1'b1; m_gid = w; m_held = 1; end
    end else if (!q[3'(m_gid)]) begin
      m_busy = 1'b0; m_ptr = (m_gid + 1) % 8;
    end else if (!e) begin
      m_busy = 1'b0;
    end
`ifdef ARB_HOLD_TIMEOUT_EN
    else if (m_held >= MAX_HOLD && (q & ~(8'd1 << m_gid)) != 8'd0) begin
      m_busy = 1'b0; m_ptr = (m_gid + 1) % 8; m_pre = 1'b1;
    end
`endif
    else m_held++;
  endtask
  task automatic cyc(input bit r, input bit e, input logic [7:0] q);
    rst = r; bus.en = e; bus.req = q;
    @(posedge clk);
    model(r, e, q);
    #1;
    check("grant", 32'(bus.grant), m_busy ? 32'd1 << m_gid : 32'd0);
    check("grant_valid", 32'(bus.grant_valid), 32'(m_busy));
    if (m_busy) check("grant_id", 32'(bus.grant_id), 32'(m_gid));
    check("preempt", 32'(bus.preempt), 32'(m_pre));
  endtask
  initial begin
    logic [7:0] q;
    bit was;
    int n;
    cyc(1, 0, 8'h00);
    cyc(1, 1, 8'hFF);
    check("reset_grant", 32'(bus.grant), 0);
    check("reset_valid", 32'(bus.grant_valid), 0);
    repeat (5) cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h14); check("plan_id2", 32'(bus.grant_id), 2);
    cyc(0, 1, 8'h10); check("plan_idle", 32'(bus.grant_valid), 0);
    cyc(0, 1, 8'h10); check("plan_id4", 32'(bus.grant), 32'h10);
    cyc(1, 1, 8'h10); check("rst_mid", 32'(bus.grant), 0);
    cyc(0, 1, 8'h81); check("rst_ptr", 32'(bus.grant_id), 0);
    cyc(0, 1, 8'h00);
    cyc(1, 1, 8'h00);
    n = 0;
    for (int t = 0; t < 60 && n < 9; t++) begin
      q = (m_busy && m_held >= 2) ? 8'hFF & ~(8'd1 << m_gid) : 8'hFF;
      was = m_busy;
      cyc(0, 1, q);
      if (m_busy && !was) begin check("order", 32'(bus.grant_id), n % 8); n++; end
    end
    check("order_count", n, 9);
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h40); check("serve6", 32'(bus.grant_id), 6);
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h01); check("wrap", 32'(bus.grant_id), 0);
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h0C); check("en_first", 32'(bus.grant_id), 2);
    cyc(0, 0, 8'h0C); check("en_cut", 32'(bus.grant), 0);
    cyc(0, 1, 8'h0C); check("en_regrant", 32'(bus.grant_id), 2);
    cyc(0, 0, 8'h08); check("simul_drop", 32'(bus.grant_valid), 0);
    cyc(0, 1, 8'h0C); check("simul_next", 32'(bus.grant_id), 3);
    cyc(0, 1, 8'h00);
`ifdef ARB_HOLD_TIMEOUT_EN
    cyc(1, 1, 8'h00);
    cyc(0, 1, 8'h0A); check("to_id1", 32'(bus.grant_id), 1);
    repeat (MAX_HOLD - 1) cyc(0, 1, 8'h0A);
    cyc(0, 1, 8'h0A); check("to_preempt", 32'(bus.preempt), 1);
    cyc(0, 1, 8'h0A); check("to_next", 32'(bus.grant_id), 3);
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h02);
    repeat (MAX_HOLD + 4) cyc(0, 1, 8'h02);
    check("to_alone", 32'(bus.grant_valid), 1);
`endif
    q = 8'h00;
    repeat (400) begin
      q ^= 8'($urandom) & 8'($urandom) & 8'($urandom);
      cyc($urandom_range(0, 79) == 0, $urandom_range(0, 9) != 0, q);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
